// File: rtl/rv32_pkg.sv
// Shared RV32 constants for the multiply unit and the hazard unit:
// M-extension funct3 encodings, multiply terminal counts and operand helpers.
package rv32_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011
  } mul_f3_e;

  // The hazard unit stalls while counter is below these values.
  localparam logic [2:0] MUL_LAST_LO = 3'd6;
  localparam logic [2:0] MUL_LAST_HI = 3'd7;

  // Terminal count for a given funct3: high-word signed/unsigned mixes need the hold cycle.
  function automatic logic [2:0] mul_last(input logic [2:0] f3);
    return f3[1] ? MUL_LAST_HI : MUL_LAST_LO;
  endfunction

  // rs1 is signed for everything except MULHU.
  function automatic logic [32:0] mul_ext_a(input logic [2:0] f3, input logic [31:0] v);
    logic sgn;
    sgn = (f3 != F3_MULHU) & v[31];
    return {sgn, v};
  endfunction

  // rs2 is signed only for MUL and MULH.
  function automatic logic [32:0] mul_ext_b(input logic [2:0] f3, input logic [31:0] v);
    logic sgn;
    sgn = ~f3[1] & v[31];
    return {sgn, v};
  endfunction

endpackage

// File: rtl/mul_chunk_acc.sv
// One radix-256 step of the sequential multiplier: the 33-bit signed
// multiplicand times an unsigned 8-bit slice of the multiplier, shifted into
// place and added to the 66-bit accumulator. Arithmetic is modulo 2^66, which
// is exact two's complement for every operand combination the unit sees.
module mul_chunk_acc (
  input  logic [65:0] p_in,
  input  logic [32:0] a,
  input  logic [7:0]  b_chunk,
  input  logic [1:0]  chunk_idx,
  output logic [65:0] p_out
);

  logic [65:0] a_ext;
  logic [65:0] b_ext;
  logic [65:0] pp;
  logic [4:0]  shamt;

  // Partial product, positioned at byte lane chunk_idx, accumulated.
  always_comb begin
    a_ext = {{33{a[32]}}, a};
    b_ext = {58'd0, b_chunk};
    pp    = a_ext * b_ext;
    shamt = {chunk_idx, 3'b000};
    p_out = p_in + (pp << shamt);
  end

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential RV32M multiplier for the EX stage. Drives the cycle counter the
// hazard unit uses to hold the pipeline, and presents the product word on the
// terminal cycle (6 for MUL/MULH, 7 for MULHSU/MULHU).
// Optional build macro: MUL_ZERO_BYPASS_EN -- a zero operand at counter 0
// jumps straight to the terminal count with a cleared product.
module mul_seq_unit
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_valid,
  input  logic        kill,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [2:0]  counter,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result
);

  logic [2:0]  counter_q, counter_d;
  logic [32:0] a_q, a_d;
  logic [32:0] b_q, b_d;
  logic [2:0]  f3_q, f3_d;
  logic [65:0] p_q, p_d;

  logic [1:0]  chunk_idx;
  logic [7:0]  b_chunk;
  logic [65:0] acc_sum;
  logic        is_term;

  // Counter 1..4 selects byte lane 0..3 of the latched multiplier.
  always_comb begin
    chunk_idx = counter_q[1:0] - 2'd1;
    b_chunk   = b_q[{chunk_idx, 3'b000} +: 8];
  end

  mul_chunk_acc u_chunk_acc (
    .p_in      (p_q),
    .a         (a_q),
    .b_chunk   (b_chunk),
    .chunk_idx (chunk_idx),
    .p_out     (acc_sum)
  );

  // Terminal detection and the externally visible handshake signals.
  always_comb begin
    is_term      = ((counter_q == MUL_LAST_LO) && !f3_q[1]) || (counter_q == MUL_LAST_HI);
    result_valid = is_term & ~kill;
    // rst_n gating keeps busy low while reset is held even if ID/EX still shows a multiply.
    busy         = rst_n & mul_valid & ~kill & ~result_valid;
    counter      = counter_q;
    result       = '0;
    if (result_valid) begin
      result = (f3_q == F3_MUL) ? p_q[31:0] : p_q[63:32];
    end
  end

  // Next-state: operand capture at counter 0, accumulate, sign fix-up, terminal return.
  always_comb begin
    counter_d = counter_q;
    a_d       = a_q;
    b_d       = b_q;
    f3_d      = f3_q;
    p_d       = p_q;
    if (kill) begin
      counter_d = 3'd0;
    end else begin
      case (counter_q)
        3'd0: begin
          if (mul_valid) begin
            a_d       = mul_ext_a(funct3, rs1_data);
            b_d       = mul_ext_b(funct3, rs2_data);
            f3_d      = funct3;
            p_d       = '0;
            counter_d = 3'd1;
`ifdef MUL_ZERO_BYPASS_EN
            if ((a_d == '0) || (b_d == '0)) begin
              counter_d = mul_last(funct3);
            end
`endif
          end
        end
        3'd1, 3'd2, 3'd3, 3'd4: begin
          p_d       = acc_sum;
          counter_d = counter_q + 3'd1;
        end
        3'd5: begin
          // Multiplier bit 32 carries weight -2^32.
          if (b_q[32]) begin
            p_d = p_q - {a_q[32], a_q, 32'd0};
          end
          counter_d = 3'd6;
        end
        3'd6: begin
          counter_d = f3_q[1] ? MUL_LAST_HI : 3'd0;
        end
        default: begin
          counter_d = 3'd0;
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      p_q       <= '0;
    end else begin
      counter_q <= counter_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      p_q       <= p_d;
    end
  end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit: table of multiplies with hand-computed
// products plus abort, reset and back-to-back sequences. Honours
// MUL_ZERO_BYPASS_EN for the zero-operand case.
module tb_mul_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mul_valid;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [2:0]  counter;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mul_seq_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mul_valid    (mul_valid),
    .kill         (kill),
    .funct3       (funct3),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .counter      (counter),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          term;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply starting at counter 0 and follow it to its terminal cycle.
  task automatic run_vec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int term);
    funct3    = f3;
    rs1_data  = a;
    rs2_data  = b;
    mul_valid = 1'b1;
    kill      = 1'b0;
    #1;
    check("start_counter", 32'(counter), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_rvalid", 32'(result_valid), 32'd0);
    for (int k = 1; k <= term; k++) begin
      tick();
      if (k == 1) begin
        // Operands are only sampled at counter 0; scramble them afterwards.
        rs1_data = ~a;
        rs2_data = b ^ 32'h5A5A_5A5A;
        #1;
      end
      check("step_counter", 32'(counter), 32'(k));
      check("step_rvalid", 32'(result_valid), (k == term) ? 32'd1 : 32'd0);
      check("step_busy", 32'(busy), (k == term) ? 32'd0 : 32'd1);
      if (k == term) check("result", result, exp);
    end
    $display("op f3=%0d a=%08h b=%08h result=%08h expected=%08h", f3, a, b, result, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b000, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 6};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 6};
    vecs[2]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 6};
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7};
    vecs[4]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 7};
    vecs[5]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 6};
    vecs[6]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 7};
    vecs[7]  = '{3'b000, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 6};
    vecs[8]  = '{3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 7};
    vecs[9]  = '{3'b000, 32'h0000_0100, 32'hFFFF_FFFF, 32'hFFFF_FF00, 6};
    vecs[10] = '{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 6};
    vecs[11] = '{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 6};

    rst_n     = 1'b0;
    mul_valid = 1'b0;
    kill      = 1'b0;
    funct3    = 3'b000;
    rs1_data  = '0;
    rs2_data  = '0;
    #1;
    check("reset_counter", 32'(counter), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rvalid", 32'(result_valid), 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("idle_counter", 32'(counter), 32'd0);

    // Table-driven multiplies, each followed by an idle cycle.
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].term);
      mul_valid = 1'b0;
      tick();
      check("post_counter", 32'(counter), 32'd0);
      check("post_rvalid", 32'(result_valid), 32'd0);
    end

    // Back-to-back: MUL terminal at 6, counter 0 next cycle, then MULHU starts.
    run_vec(3'b000, 32'd3, 32'd5, 32'd15, 6);
    tick();
    run_vec(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 7);
    mul_valid = 1'b0;
    tick();
    check("b2b_idle", 32'(counter), 32'd0);

    // Kill at counter 3.
    funct3 = 3'b000; rs1_data = 32'd7; rs2_data = 32'd6; mul_valid = 1'b1;
    repeat (3) tick();
    check("kill3_counter", 32'(counter), 32'd3);
    kill = 1'b1;
    #1;
    check("kill3_rvalid", 32'(result_valid), 32'd0);
    check("kill3_busy", 32'(busy), 32'd0);
    tick();
    check("kill3_next", 32'(counter), 32'd0);
    kill = 1'b0; mul_valid = 1'b0;
    tick();
    check("kill3_idle", 32'(counter), 32'd0);
    $display("kill at counter 3 done, counter=%0d", counter);

    // Kill coincident with the terminal cycle.
    mul_valid = 1'b1;
    repeat (6) tick();
    check("killT_counter", 32'(counter), 32'd6);
    kill = 1'b1;
    #1;
    check("killT_rvalid", 32'(result_valid), 32'd0);
    tick();
    check("killT_next", 32'(counter), 32'd0);
    kill = 1'b0; mul_valid = 1'b0;
    tick();
    $display("kill at terminal done, counter=%0d", counter);

    // Asynchronous reset at counter 4, then restart with mul_valid held.
    mul_valid = 1'b1;
    repeat (4) tick();
    check("rst_pre_counter", 32'(counter), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_counter", 32'(counter), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rvalid", 32'(result_valid), 32'd0);
    check("rst_result", result, 32'd0);
    tick();
    check("rst_hold", 32'(counter), 32'd0);
    #2;
    rst_n = 1'b1;
    run_vec(3'b000, 32'd7, 32'd6, 32'd42, 6);
    mul_valid = 1'b0;
    tick();

`ifdef MUL_ZERO_BYPASS_EN
    // Zero operand skips straight to the terminal count.
    funct3 = 3'b000; rs1_data = 32'd0; rs2_data = 32'd5; mul_valid = 1'b1;
    #1;
    check("byp_start", 32'(counter), 32'd0);
    tick();
    check("byp_counter", 32'(counter), 32'd6);
    check("byp_rvalid", 32'(result_valid), 32'd1);
    check("byp_result", result, 32'd0);
    mul_valid = 1'b0;
    tick();
    check("byp_idle", 32'(counter), 32'd0);
    $display("bypass MUL 0x5 result=%08h", result);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mul_seq_unit.md
# mul_seq_unit

Multi-cycle RV32M multiplier in the EX stage; the producing end of the multiply-stall handshake consumed by the hazard detection unit. While ID/EX holds a multiply, it drives a 3-bit cycle `counter`. The hazard unit stalls PC, IF/ID and ID/EX until `counter` reaches the terminal count selected by `funct3[1]`. On the terminal cycle the block presents the 32-bit result to the EX result mux.

## Interface
- No parameters. Terminal counts are fixed by the stall contract (see Structure).
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mul_valid`  in  1  ID/EX holds an M-extension multiply (opcode OP, funct7 0000001, funct3[2]=0). Held high by the stall until the terminal cycle.
- `kill`  in  1  ID/EX instruction squashed; abort the operation.
- `funct3`  in  3  ID/EX funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `rs1_data`, `rs2_data`  in  32  forwarded operands; sampled only at counter 0.
- `counter`  out  3  cycle counter to the hazard unit.
- `busy`  out  1  `mul_valid & ~kill & ~result_valid`.
- `result_valid`  out  1  high for exactly the terminal cycle.
- `result`  out  32  product word; valid only while `result_valid`.

## Operation
- Operand extension at counter 0 gives A (33 bits) and B (33 bits):
  - A is sign-extended for MUL, MULH and MULHSU; zero-extended for MULHU.
  - B is sign-extended for MUL and MULH; zero-extended for MULHSU and MULHU.
- 66-bit accumulator P; 8-bit chunk of B[31:0] per cycle.
- Counter 0, `mul_valid & ~kill`:
  - Latch A, B and funct3.
  - Clear P.
  - counter → 1.
- Counter 0, no `mul_valid`: hold at 0.
- Counter 1..4: P += A × B[8k-1:8k-8] << (8(k-1)), with k = counter. Arithmetic is signed 66-bit.
- Counter 5: if B[32]=1, P -= A << 32. Then counter → 6.
- Counter 6:
  - Latched funct3[1]=0: terminal cycle.
  - Latched funct3[1]=1: hold cycle. P is unchanged and counter → 7.
- Counter 7: terminal cycle for funct3[1]=1.
- Terminal cycle:
  - `result_valid`=1.
  - `result` = P[31:0] for MUL; P[63:32] for all other funct3 values.
  - counter → 0 on the next edge, so a back-to-back multiply starts cleanly.
- `kill` in any state: counter → 0 next edge. `result_valid` is forced 0 in that cycle.
- The counter never exceeds 7. There is no wrap from 7 to 0 other than the terminal return.

## Timing
- Reset values: `counter`=0, `busy`=0, `result_valid`=0, `result`=0. Internal A, B, P and funct3 are cleared.
- Latency from the first cycle `mul_valid` is seen:
  - funct3[1]=0: 7 cycles (counter 0..6).
  - funct3[1]=1: 8 cycles (counter 0..7).
- Consistency with the hazard unit: it stalls while counter<6 (funct3[1]=0) or counter<7 (funct3[1]=1). The pipeline therefore advances exactly on the terminal cycle.
- `result` is driven from the P register through a mux. There is no combinational path from `rs1_data`/`rs2_data` to `result`.
- `kill` coincident with the terminal cycle: no `result_valid`; counter → 0.
- `rst_n` asserted mid-operation: all outputs zero immediately (asynchronous). Operation restarts from counter 0 after deassertion if `mul_valid` is still high.
- Operand changes after counter 0 are ignored.

## Configuration
- `MUL_ZERO_BYPASS_EN` defined:
  - If A=0 or B=0 at counter 0, clear P and jump counter directly to the terminal value (6 or 7) on the next edge.
  - Latency becomes 2 cycles.
  - The hazard unit contract still holds because it stalls only on counter<terminal.
- `MUL_ZERO_BYPASS_EN` undefined: fixed latency for all operands.

## Structure
- Shared package (`rv32_pkg`) holds:
  - funct3 encodings `F3_MUL`, `F3_MULH`, `F3_MULHSU`, `F3_MULHU`.
  - Terminal counts `MUL_LAST_LO`=3'd6 and `MUL_LAST_HI`=3'd7. The hazard unit compares against these same constants.
- One sub-module, `mul_chunk_acc`: a combinational 33×8 signed-by-unsigned partial product, shifted and added to the 66-bit P.
- The counter, operand latches and result mux live in `mul_seq_unit`.

## Test plan
- MUL 7×6, `mul_valid` held:
  - counter steps 0..6.
  - `result_valid` only at counter 6, with `result`=42.
  - counter=0 on the next cycle.
- MULH 0xFFFFFFFF × 0xFFFFFFFF: `result`=0x00000000 at counter 6. The same operands with MUL give 0x00000001.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF:
  - counter reaches 7.
  - `result_valid` is low at counter 6 and high at counter 7.
  - `result`=0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0x00000002: `result`=0xFFFFFFFF at counter 7.
- Back-to-back MUL then MULHU with no gap: counter runs 6 → 0 → 1. Abort case: `kill` at counter 3 gives counter=0 next cycle and no `result_valid`.
- Reset case: `rst_n` low at counter 4 gives counter=0, `busy`=0 and `result`=0 immediately. With `MUL_ZERO_BYPASS_EN`: MUL 0×5 gives counter 0 → 6, with `result`=0 on cycle 2.
